// File: rtl/sign_extender_pkg.sv
// Shared constants for immediate generation: format encodings and field positions/widths.
package sign_extender_pkg;

    typedef enum logic [1:0] {
        CTRL_I  = 2'b00,
        CTRL_D  = 2'b01,
        CTRL_B  = 2'b10,
        CTRL_CB = 2'b11
    } ctrl_e;

    localparam int unsigned IMM_IN_W = 26;
    localparam int unsigned IMM_W    = 64;

    localparam int unsigned I_MSB  = 21;
    localparam int unsigned I_LSB  = 10;
    localparam int unsigned D_MSB  = 20;
    localparam int unsigned D_LSB  = 12;
    localparam int unsigned B_MSB  = 25;
    localparam int unsigned B_LSB  = 0;
    localparam int unsigned CB_MSB = 23;
    localparam int unsigned CB_LSB = 5;

    localparam int unsigned I_W  = 12;
    localparam int unsigned D_W  = 9;
    localparam int unsigned B_W  = 26;
    localparam int unsigned CB_W = 19;

endpackage

// File: rtl/sign_extender_core.sv
// Combinational mapping of the 26-bit instruction immediate field to a 64-bit immediate.
module sign_extender_core
    import sign_extender_pkg::*;
(
    input  logic [IMM_IN_W-1:0] Imm26,
    input  logic [1:0]          Ctrl,
    output logic [IMM_W-1:0]    BusImm
);

    always_comb begin
        BusImm = '0;
        case (ctrl_e'(Ctrl))
            CTRL_I:  BusImm = {{(IMM_W-I_W){1'b0}}, Imm26[I_MSB:I_LSB]};
            CTRL_D:  BusImm = {{(IMM_W-D_W){Imm26[D_MSB]}}, Imm26[D_MSB:D_LSB]};
            CTRL_B:  BusImm = {{(IMM_W-B_W){Imm26[B_MSB]}}, Imm26[B_MSB:B_LSB]};
            CTRL_CB: BusImm = {{(IMM_W-CB_W){Imm26[CB_MSB]}}, Imm26[CB_MSB:CB_LSB]};
            default: BusImm = '0;
        endcase
    end

endmodule

// File: rtl/sign_extender.sv
// Immediate generator: combinational result plus an enable-gated registered copy with valid flag.
module sign_extender
    import sign_extender_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [IMM_IN_W-1:0] Imm26,
    input  logic [1:0]          Ctrl,
    input  logic                En,
    output logic [IMM_W-1:0]    BusImm,
    output logic [IMM_W-1:0]    BusImmReg,
    output logic                ImmValid
);

    sign_extender_core u_core (
        .Imm26  (Imm26),
        .Ctrl   (Ctrl),
        .BusImm (BusImm)
    );

    // Pipeline copy; ImmValid marks a capture since the last reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            BusImmReg <= '0;
            ImmValid  <= 1'b0;
        end else if (En) begin
            BusImmReg <= BusImm;
            ImmValid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
// Directed self-checking bench for sign_extender.
module tb_sign_extender;

    logic        Clk;
    logic        Reset_n;
    logic [25:0] Imm26;
    logic [1:0]  Ctrl;
    logic        En;
    logic [63:0] BusImm;
    logic [63:0] BusImmReg;
    logic        ImmValid;

    int n_checks = 0;
    int n_fails  = 0;

    sign_extender dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Imm26     (Imm26),
        .Ctrl      (Ctrl),
        .En        (En),
        .BusImm    (BusImm),
        .BusImmReg (BusImmReg),
        .ImmValid  (ImmValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic comb(input string tag, input logic [1:0] c, input logic [25:0] imm,
                        input logic [63:0] exp);
        Ctrl  = c;
        Imm26 = imm;
        #1;
        chk(tag, BusImm, exp);
    endtask

    initial begin
        Reset_n = 1'b0;
        En      = 1'b0;
        Ctrl    = 2'b00;
        Imm26   = 26'h0;
        #1;
        // Reset seen before any clock edge
        chk("reset_reg", BusImmReg, 64'h0);
        chk("reset_valid", {63'h0, ImmValid}, 64'h0);

        comb("zero_i",  2'b00, 26'h0, 64'h0);
        comb("zero_d",  2'b01, 26'h0, 64'h0);
        comb("zero_b",  2'b10, 26'h0, 64'h0);
        comb("zero_cb", 2'b11, 26'h0, 64'h0);

        comb("one_i",  2'b00, 26'h0000001, 64'h0);
        comb("one_d",  2'b01, 26'h0000001, 64'h0);
        comb("one_b",  2'b10, 26'h0000001, 64'h1);
        comb("one_cb", 2'b11, 26'h0000001, 64'h0);

        comb("ones_i",  2'b00, 26'h3FFFFFF, 64'h0000000000000FFF);
        comb("ones_d",  2'b01, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFF);
        comb("ones_b",  2'b10, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFF);
        comb("ones_cb", 2'b11, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFF);

        comb("iso_d_bit20", 2'b01, 26'h0100000, 64'hFFFFFFFFFFFFFF00);
        comb("iso_cb_bit5", 2'b11, 26'h0000020, 64'h1);
        comb("iso_i_lsb",   2'b00, 26'h0000400, 64'h1);
        comb("iso_i_msb",   2'b00, 26'h0200000, 64'h800);
        comb("iso_d_lsb",   2'b01, 26'h0001000, 64'h1);
        comb("iso_b_msb",   2'b10, 26'h2000000, 64'hFFFFFFFFFE000000);
        comb("iso_cb_msb",  2'b11, 26'h0800000, 64'hFFFFFFFFFFFC0000);
        comb("iso_cb_out",  2'b11, 26'h300001F, 64'h0);
        comb("mix_d",       2'b01, 26'h00AB000, 64'h00000000000000AB);
        comb("mix_b",       2'b10, 26'h1234567, 64'h0000000001234567);

        // Reset release and En=1 on the same edge captures normally
        chk("still_reset_reg", BusImmReg, 64'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        Ctrl    = 2'b10;
        Imm26   = 26'h0000001;
        En      = 1'b1;
        @(posedge Clk);
        #1;
        chk("cap_reg", BusImmReg, 64'h1);
        chk("cap_valid", {63'h0, ImmValid}, 64'h1);
        chk("cap_comb", BusImm, 64'h1);

        // Hold with En=0 while inputs change
        @(negedge Clk);
        En    = 1'b0;
        Ctrl  = 2'b01;
        Imm26 = 26'h3FFFFFF;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        chk("hold_reg", BusImmReg, 64'h1);
        chk("hold_valid", {63'h0, ImmValid}, 64'h1);
        chk("hold_comb", BusImm, 64'hFFFFFFFFFFFFFFFF);

        // Second capture
        @(negedge Clk);
        En    = 1'b1;
        Ctrl  = 2'b00;
        Imm26 = 26'h0ABCDEF;
        @(posedge Clk);
        #1;
        chk("cap2_reg", BusImmReg, 64'h0000000000000AF3);
        En = 1'b0;

        // Async reset between edges clears at once; comb path unaffected
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("async_reg", BusImmReg, 64'h0);
        chk("async_valid", {63'h0, ImmValid}, 64'h0);
        chk("async_comb", BusImm, 64'h0000000000000AF3);

        // En while in reset does not capture
        En = 1'b1;
        @(posedge Clk);
        #1;
        chk("inreset_reg", BusImmReg, 64'h0);
        chk("inreset_valid", {63'h0, ImmValid}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
